// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the bit-serial link (transmitter and matching receiver).
// Contents:
//   state_e   - frame FSM state encoding (IDLE / SHIFT / PARITY)
//   STATE_W   - width of the state encoding
//   cnt_width - bit-count register width for a given word width (minimum 1)
package piso_serial_tx_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Count register width: enough to hold 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 32'd2) ? 32'd1 : unsigned'($clog2(width));
    endfunction

endpackage

// File: rtl/piso_serial_tx_dff_ar.sv
// 1-bit D flip-flop with asynchronous active-high reset to 0.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous reset, active high
//   i_d - next value
//   o_q - registered value
module piso_serial_tx_dff_ar (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= 1'b0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock on sout, qualified by sout_valid.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit per frame.
// Parameters:
//   WIDTH     - data word width (>=2)
//   MSB_FIRST - 0: bit 0 first, 1: bit WIDTH-1 first
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active high
//   load_valid - word offered on load_data
//   load_ready - block can accept a word (combinational, state==IDLE)
//   load_data  - parallel word, sampled only on the accept edge
//   sout       - serial data bit (registered)
//   sout_valid - sout carries a frame bit (registered)
//   busy       - frame in progress (state!=IDLE)
//   done       - one-cycle pulse in the first idle cycle after a frame (registered)
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] w_state_q;
    logic [STATE_W-1:0] w_state_d;
    state_e             w_state;
    state_e             w_state_nxt;

    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_sout_nxt;
    logic               w_sout_valid_nxt;
    logic               w_done_nxt;

`ifdef PISO_PARITY_EN
    logic               r_parity;
    logic               w_parity_nxt;
`endif

    // State bits held in individual reset flops.
    for (genvar g = 0; g < int'(STATE_W); g++) begin : g_state_ff
        piso_serial_tx_dff_ar u_state_ff (
            .clk (clk),
            .rst (rst),
            .i_d (w_state_d[g]),
            .o_q (w_state_q[g])
        );
    end

    assign w_state   = state_e'(w_state_q);
    assign w_state_d = w_state_nxt;

    piso_serial_tx_dff_ar u_sout_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_sout_nxt),
        .o_q (sout)
    );

    piso_serial_tx_dff_ar u_sout_valid_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_sout_valid_nxt),
        .o_q (sout_valid)
    );

    piso_serial_tx_dff_ar u_done_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_done_nxt),
        .o_q (done)
    );

    // Shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity of the captured word, latched at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    // Next-state and next-output logic. The shift register always holds the
    // bits not yet sent, aligned so the next one sits at the outgoing end.
    always_comb begin
        w_state_nxt      = w_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_sout_nxt       = sout;
        w_sout_valid_nxt = sout_valid;
        w_done_nxt       = 1'b0;
`ifdef PISO_PARITY_EN
        w_parity_nxt     = r_parity;
`endif

        case (w_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_state_nxt      = ST_SHIFT;
                    w_cnt_nxt        = '0;
                    w_sout_valid_nxt = 1'b1;
`ifdef PISO_PARITY_EN
                    w_parity_nxt     = ^load_data;
`endif
                    if (MSB_FIRST != 0) begin
                        w_sout_nxt  = load_data[WIDTH-1];
                        w_shift_nxt = {load_data[WIDTH-2:0], 1'b0};
                    end else begin
                        w_sout_nxt  = load_data[0];
                        w_shift_nxt = {1'b0, load_data[WIDTH-1:1]};
                    end
                end
            end

            ST_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                    w_state_nxt      = ST_PARITY;
                    w_sout_nxt       = r_parity;
`else
                    w_state_nxt      = ST_IDLE;
                    w_sout_nxt       = 1'b0;
                    w_sout_valid_nxt = 1'b0;
                    w_done_nxt       = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (MSB_FIRST != 0) begin
                        w_sout_nxt  = r_shift[WIDTH-1];
                        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    end else begin
                        w_sout_nxt  = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
                    end
                end
            end

`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                w_state_nxt      = ST_IDLE;
                w_sout_nxt       = 1'b0;
                w_sout_valid_nxt = 1'b0;
                w_done_nxt       = 1'b1;
            end
`endif

            default: begin
                w_state_nxt      = ST_IDLE;
                w_sout_nxt       = 1'b0;
                w_sout_valid_nxt = 1'b0;
            end
        endcase
    end

    assign load_ready = (w_state == ST_IDLE);
    assign busy       = (w_state != ST_IDLE);

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: inst0 LSB-first, inst1 MSB-first, WIDTH=8.
// A frame-position model predicts every output each cycle; directed tests
// add literal expectations on captured serial streams and counts.
module tb_piso_serial_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv0, lv1;
    logic [7:0] ld0, ld1;
    logic       rdy0, rdy1, sout0, sout1, sv0, sv1, busy0, busy1, done0, done1;

    int         cmp_n  = 0;
    int         fail_n = 0;
    int         cyc    = 0;

    int         ph [2];
    logic [7:0] wd [2];

    logic       cap0 [$];
    logic       cap1 [$];
    int         st0  [$];
    logic       pv0 = 1'b0;
    logic       pv1 = 1'b0;
    int         nbusy0 = 0, nbusy1 = 0, ndone0 = 0, ndone1 = 0, ndr0 = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv0),
        .load_ready (rdy0),
        .load_data  (ld0),
        .sout       (sout0),
        .sout_valid (sv0),
        .busy       (busy0),
        .done       (done0)
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv1),
        .load_ready (rdy1),
        .load_data  (ld1),
        .sout       (sout1),
        .sout_valid (sv1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmp_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // k-th bit on the wire for word d: data bits in send order, then parity.
    function automatic logic frame_bit(input logic [7:0] d, input bit msb, input int k);
        if (k < 8) return msb ? d[7-k] : d[k];
        return ^d;
    endfunction

    // Expected {sout, sout_valid, busy, done, load_ready} from frame position.
    function automatic logic [4:0] expect_vec(input int i);
        int p;
        p = ph[i];
        if (p >= 1 && p <= FL) return {frame_bit(wd[i], (i == 1), p - 1), 1'b1, 1'b1, 1'b0, 1'b0};
        if (p == FL + 1)       return 5'b00011;
        return 5'b00001;
    endfunction

    // Advance the model across a rising edge using the inputs held at that edge.
    function automatic void model_step();
        logic       l;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            l = (i == 0) ? lv0 : lv1;
            d = (i == 0) ? ld0 : ld1;
            if (rst) ph[i] = 0;
            else if ((ph[i] == 0 || ph[i] == FL + 1) && l) begin
                ph[i] = 1;
                wd[i] = d;
            end else if (ph[i] >= 1 && ph[i] <= FL) ph[i] = ph[i] + 1;
            else ph[i] = 0;
        end
    endfunction

    task automatic compare_cycle();
        if (rst) begin
            pv0 = 1'b0;
            pv1 = 1'b0;
            return;
        end
        check($sformatf("cyc%0d_inst0_outs", cyc), 32'({sout0, sv0, busy0, done0, rdy0}), 32'(expect_vec(0)));
        check($sformatf("cyc%0d_inst1_outs", cyc), 32'({sout1, sv1, busy1, done1, rdy1}), 32'(expect_vec(1)));
        if (sv0) cap0.push_back(sout0);
        if (sv1) cap1.push_back(sout1);
        if (sv0 && !pv0) st0.push_back(cyc);
        pv0 = sv0;
        pv1 = sv1;
        if (busy0) nbusy0++;
        if (busy1) nbusy1++;
        if (done0) ndone0++;
        if (done1) ndone1++;
        if (done0 && rdy0) ndr0++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // Captured bits s..s+7 packed so that bit i is the i-th bit sent.
    function automatic logic [7:0] word0(input int s);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = (s + i < cap0.size()) ? cap0[s+i] : 1'bx;
        return w;
    endfunction

    function automatic logic [7:0] word1(input int s);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = (s + i < cap1.size()) ? cap1[s+i] : 1'bx;
        return w;
    endfunction

    task automatic send0(input logic [7:0] d);
        lv0 = 1'b1;
        ld0 = d;
        tick();
        lv0 = 1'b0;
        ld0 = ~d;
        repeat (FL + 2) tick();
    endtask

    task automatic send1(input logic [7:0] d);
        lv1 = 1'b1;
        ld1 = d;
        tick();
        lv1 = 1'b0;
        ld1 = ~d;
        repeat (FL + 2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s, s1, d0, d1, b1, ss, gap;
        lv0 = 1'b0; lv1 = 1'b0; ld0 = '0; ld1 = '0;
        ph[0] = 0; ph[1] = 0; wd[0] = '0; wd[1] = '0;

        // Reset state
        repeat (2) tick();
        check("rst_inst0_outs", 32'({sout0, sv0, busy0, done0}), 32'(4'b0000));
        check("rst_inst1_outs", 32'({sout1, sv1, busy1, done1}), 32'(4'b0000));
        rst = 1'b0;
        #1;
        check("rst_release_ready0", 32'(rdy0), 32'(1));
        check("rst_release_ready1", 32'(rdy1), 32'(1));

        // Idle for 20 cycles
        s = cap0.size(); s1 = cap1.size(); d0 = ndone0; d1 = ndone1;
        repeat (20) tick();
        check("idle_valid0", 32'(cap0.size() - s), 32'(0));
        check("idle_valid1", 32'(cap1.size() - s1), 32'(0));
        check("idle_done0", 32'(ndone0 - d0), 32'(0));
        check("idle_done1", 32'(ndone1 - d1), 32'(0));

        // LSB-first A5
        s = cap0.size(); d0 = ndr0;
        send0(8'hA5);
        check("a5_bits", 32'(word0(s)), 32'(8'hA5));
        check("a5_valid_len", 32'(cap0.size() - s), 32'(FL));
        check("a5_done_with_ready", 32'(ndr0 - d0), 32'(1));
`ifdef PISO_PARITY_EN
        check("a5_parity", 32'((s + 8 < cap0.size()) ? cap0[s+8] : 1'bx), 32'(0));
`endif

        // MSB-first 81 and 01
        s1 = cap1.size(); b1 = nbusy1;
        send1(8'h81);
        check("msb81_bits", 32'(word1(s1)), 32'(8'h81));
        check("msb81_busy_len", 32'(nbusy1 - b1), 32'(FL));
        s1 = cap1.size();
        send1(8'h01);
        check("msb01_bits", 32'(word1(s1)), 32'(8'h80));

`ifdef PISO_PARITY_EN
        // Parity frame 07
        s = cap0.size();
        send0(8'h07);
        check("p07_bits", 32'(word0(s)), 32'(8'h07));
        check("p07_parity", 32'((s + 8 < cap0.size()) ? cap0[s+8] : 1'bx), 32'(1));
        check("p07_valid_len", 32'(cap0.size() - s), 32'(9));
`endif

        // Back-to-back with load_valid held, data changed mid-frame
        s = cap0.size(); ss = st0.size();
        lv0 = 1'b1; ld0 = 8'h3C;
        tick();
        ld0 = 8'hC3;
        repeat (FL + 1) tick();
        ld0 = 8'h5A;
        repeat (3) tick();
        lv0 = 1'b0;
        repeat (FL + 1) tick();
        check("b2b_first", 32'(word0(s)), 32'(8'h3C));
        check("b2b_second", 32'(word0(s + FL)), 32'(8'hC3));
        gap = (st0.size() >= ss + 2) ? st0[ss+1] - st0[ss] : -1;
        check("b2b_start_spacing", 32'(gap), 32'(FL + 1));
        check("b2b_total_bits", 32'(cap0.size() - s), 32'(2 * FL));

        // Async reset mid-frame at bit 4 of FF
        lv0 = 1'b1; ld0 = 8'hFF;
        tick();
        lv0 = 1'b0;
        repeat (4) tick();
        check("rstmid_before", 32'({sout0, sv0, busy0}), 32'(3'b111));
        d0 = ndone0;
        rst = 1'b1;
        #1;
        check("rstmid_async_outs", 32'({sout0, sv0, busy0, done0}), 32'(4'b0000));
        ph[0] = 0; ph[1] = 0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rstmid_ready", 32'(rdy0), 32'(1));
        repeat (3) tick();
        check("rstmid_no_done", 32'(ndone0 - d0), 32'(0));
        s = cap0.size();
        send0(8'h01);
        check("rstmid_fresh_01", 32'(word0(s)), 32'(8'h01));
        check("rstmid_fresh_len", 32'(cap0.size() - s), 32'(FL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
